// File: rtl/pc_seq_pkg.sv
// Shared opcode constants, FSM state encoding and opcode classification for pc_sequencer.
// Optional BNE support is enabled by defining PC_SEQ_BNE_EN.
package pc_seq_pkg;

  localparam logic [7:0] OP_J   = 8'h06;
  localparam logic [7:0] OP_BEQ = 8'h07;
  localparam logic [7:0] OP_LWD = 8'h08;
  localparam logic [7:0] OP_LWI = 8'h09;
  localparam logic [7:0] OP_SWD = 8'h0A;
  localparam logic [7:0] OP_SWI = 8'h0B;
  localparam logic [7:0] OP_BNE = 8'h0C;

  localparam logic [31:0] PC_INC = 32'd4;

  typedef enum logic [1:0] {
    S_RST   = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_MEM   = 2'd3
  } state_t;

  // How the next PC is chosen once an instruction retires.
  typedef enum logic [1:0] {
    CLS_SEQ  = 2'd0,
    CLS_JUMP = 2'd1,
    CLS_BEQ  = 2'd2,
    CLS_BNE  = 2'd3
  } op_class_t;

  function automatic op_class_t classify(input logic [7:0] op);
    op_class_t cls;
    cls = CLS_SEQ;
    case (op)
      OP_J:    cls = CLS_JUMP;
      OP_BEQ:  cls = CLS_BEQ;
`ifdef PC_SEQ_BNE_EN
      OP_BNE:  cls = CLS_BNE;
`endif
      default: cls = CLS_SEQ;
    endcase
    return cls;
  endfunction

  function automatic logic is_load(input logic [7:0] op);
    return (op == OP_LWD) || (op == OP_LWI);
  endfunction

  function automatic logic is_store(input logic [7:0] op);
    return (op == OP_SWD) || (op == OP_SWI);
  endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection: sequential, jump, or conditional branch target.
// All arithmetic is 32-bit and wraps modulo 2^32.
module pc_next_calc
  import pc_seq_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [7:0]  offset,
  input  op_class_t   op_class,
  input  logic        zero,
  output logic [31:0] next_pc
);

  logic [31:0] seq_pc;
  logic [31:0] target_pc;

  assign seq_pc    = pc + PC_INC;
  // Offset is a signed word count relative to the following instruction.
  assign target_pc = seq_pc + {{22{offset[7]}}, offset, 2'b00};

  always_comb begin
    next_pc = seq_pc;
    case (op_class)
      CLS_JUMP: next_pc = target_pc;
      CLS_BEQ:  next_pc = zero ? target_pc : seq_pc;
      CLS_BNE:  next_pc = zero ? seq_pc : target_pc;
      default:  next_pc = seq_pc;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle FETCH/EXEC/MEM sequencer owning the PC; emits COMMIT per retired instruction.
// Optional BNE opcode enabled by defining PC_SEQ_BNE_EN (see pc_seq_pkg).
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [7:0]  OPCODE,
  input  logic [7:0]  OFFSET,
  input  logic        ZERO,
  input  logic        IBUSY,
  input  logic        DBUSY,
  output logic [31:0] PC,
  output logic        IREAD,
  output logic        DREAD,
  output logic        DWRITE,
  output logic        COMMIT,
  output logic        STALL
);

  state_t      state;
  op_class_t   calc_class;
  logic [31:0] next_pc;
  logic        op_load;
  logic        op_store;

  assign op_load  = is_load(OPCODE);
  assign op_store = is_store(OPCODE);

  // A memory-phase retire always advances sequentially, so the branch
  // decode only steers the calculator while in EXEC.
  assign calc_class = (state == S_EXEC) ? classify(OPCODE) : CLS_SEQ;

  pc_next_calc u_pc_next_calc (
    .pc       (PC),
    .offset   (OFFSET),
    .op_class (calc_class),
    .zero     (ZERO),
    .next_pc  (next_pc)
  );

  // Gated by RESET so an instruction cut off by reset never signals a retire.
  assign COMMIT = RESET &&
                  (((state == S_EXEC) && !op_load && !op_store) ||
                   ((state == S_MEM) && !DBUSY));

  assign STALL = ((state == S_FETCH) && IBUSY) ||
                 ((state == S_MEM)   && DBUSY);

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state  <= S_RST;
      PC     <= RESET_PC;
      IREAD  <= 1'b0;
      DREAD  <= 1'b0;
      DWRITE <= 1'b0;
    end else begin
      case (state)
        S_RST: begin
          PC    <= RESET_PC;
          IREAD <= 1'b1;
          state <= S_FETCH;
        end
        S_FETCH: begin
          if (!IBUSY) begin
            IREAD <= 1'b0;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (op_load) begin
            DREAD <= 1'b1;
            state <= S_MEM;
          end else if (op_store) begin
            DWRITE <= 1'b1;
            state  <= S_MEM;
          end else begin
            PC    <= next_pc;
            IREAD <= 1'b1;
            state <= S_FETCH;
          end
        end
        S_MEM: begin
          if (!DBUSY) begin
            PC     <= next_pc;
            DREAD  <= 1'b0;
            DWRITE <= 1'b0;
            IREAD  <= 1'b1;
            state  <= S_FETCH;
          end
        end
        default: begin
          IREAD  <= 1'b0;
          DREAD  <= 1'b0;
          DWRITE <= 1'b0;
          state  <= S_RST;
        end
      endcase
    end
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Multi-cycle instruction sequencer for the processor core. Owns the program counter and walks each instruction through fetch, execute and optional data-memory phases, handshaking with the instruction and data memories through their busy-wait signals. It produces the single-cycle `COMMIT` strobe that qualifies register-file writes and PC updates. It sits between the decode stage (opcode, offset) and the memories.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.

Ports:
- `CLK`  in  1  system clock; all state changes on the rising edge.
- `RESET`  in  1  synchronous, active-low reset.
- `OPCODE`  in  8  decoded opcode, instruction bits [31:24].
- `OFFSET`  in  8  branch/jump word offset, instruction bits [23:16], signed.
- `ZERO`  in  1  ALU zero flag for the current instruction.
- `IBUSY`  in  1  instruction-memory busy-wait; high = fetch not complete.
- `DBUSY`  in  1  data-memory busy-wait; high = access not complete.
- `PC`  out  32  current instruction address (registered).
- `IREAD`  out  1  instruction fetch request (registered).
- `DREAD`  out  1  data read request (registered).
- `DWRITE`  out  1  data write request (registered).
- `COMMIT`  out  1  one-cycle strobe: instruction retires; register-file write enable is ANDed with it externally.
- `STALL`  out  1  combinational; high while waiting on a busy memory.

## Operation
- States: `S_RST`, `S_FETCH`, `S_EXEC`, `S_MEM`.
- `S_RST`: `PC` = `RESET_PC`, all requests low. Next cycle goes to `S_FETCH`.
- `S_FETCH`: `IREAD` = 1. If `IBUSY` = 0, go to `S_EXEC`. Otherwise stay.
- `S_EXEC`: decode `OPCODE`.
  - Load opcodes (`LWD` 8'h08, `LWI` 8'h09): set `DREAD`, go to `S_MEM`.
  - Store opcodes (`SWD` 8'h0A, `SWI` 8'h0B): set `DWRITE`, go to `S_MEM`.
  - All other opcodes: `COMMIT` = 1, update `PC`, go to `S_FETCH`.
- `S_MEM`: hold `DREAD`/`DWRITE`. If `DBUSY` = 0: `COMMIT` = 1, `PC` += 4, drop the request, go to `S_FETCH`. Otherwise stay.
- PC update on a non-memory commit:
  - `J` (8'h06): target.
  - `BEQ` (8'h07): target if `ZERO` = 1, else `PC` + 4.
  - Any other opcode: `PC` + 4.
  - Target = `PC` + 4 + (sign-extended `OFFSET` << 2). All PC arithmetic is 32-bit modulo 2^32 (wraps silently).
- Unknown opcodes retire as no-ops: `COMMIT` is asserted and `PC` advances by 4.
- `STALL` = (`S_FETCH` and `IBUSY`) or (`S_MEM` and `DBUSY`).

## Timing
- Reset values: `PC` = `RESET_PC`; `IREAD`, `DREAD`, `DWRITE`, `COMMIT`, `STALL` = 0.
- `RESET` low in any state, including mid-fetch or mid-memory-wait, forces `S_RST` at the next edge. Outstanding requests drop immediately with no commit.
- Minimum latency:
  - Non-memory instruction: 2 cycles (FETCH, EXEC).
  - Memory instruction: 3 cycles (FETCH, EXEC, MEM).
- `IREAD` is high for the whole of `S_FETCH` and low in every other state.
- Memories must raise busy combinationally in the same cycle the request is first seen. Busy low in the first request cycle means single-cycle completion.
- `DBUSY` is ignored outside `S_MEM`; `IBUSY` is ignored outside `S_FETCH`.
- `COMMIT` is high for exactly one cycle per retired instruction. The new `PC` is visible the cycle after `COMMIT`.
- `OPCODE`, `OFFSET` and `ZERO` are sampled only in `S_EXEC`. They must be stable from `S_EXEC` through `S_MEM`.

## Configuration
- `PC_SEQ_BNE_EN` defined: opcode `BNE` (8'h0C) branches to target when `ZERO` = 0, else `PC` + 4.
- `PC_SEQ_BNE_EN` undefined: 8'h0C is an unknown opcode and retires as a no-op (`PC` + 4).

## Structure
- Package `pc_seq_pkg` holds:
  - opcode constants (`OP_J`, `OP_BEQ`, `OP_BNE`, `OP_LWD`, `OP_LWI`, `OP_SWD`, `OP_SWI`);
  - state encoding (2-bit);
  - PC increment constant (4).
- Sub-module `pc_next_calc` is combinational: inputs `PC`, `OFFSET`, opcode class, `ZERO`; output next PC. The FSM stays in `pc_sequencer`.

## Test plan
- Reset then `IBUSY` = 0, opcode 8'h00 → `IREAD` high in cycle 1, `COMMIT` in cycle 2, `PC` = 4 in cycle 3.
- `J` with `OFFSET` = 8'hFE at `PC` = 8 → `PC` = 8 + 4 − 8 = 4; with `OFFSET` = 8'h03 → `PC` = 24.
- `BEQ` with `OFFSET` = 2 at `PC` = 0: `ZERO` = 1 → `PC` = 12; `ZERO` = 0 → `PC` = 4. `BNE` runs both cases with and without `PC_SEQ_BNE_EN`.
- `LWD` with `DBUSY` high for 3 cycles → `DREAD` high 4 cycles, `STALL` high 3 cycles, one `COMMIT`, `PC` += 4.
- `IBUSY` high 5 cycles, then `RESET` low during a `SWI` `S_MEM` wait → requests drop next edge, no `COMMIT`, `PC` = `RESET_PC`.
- `PC` = 32'hFFFF_FFFC, opcode 8'h00 → `PC` wraps to 0.
